// File: rtl/salva_contexto_pkg.sv
// Shared CPU package: context-transfer FSM encoding and transfer mode constants.
package salva_contexto_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_REQ = 3'd1,
    LOAD_REQ = 3'd2,
    LOAD_WR  = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Values of the modo input
  localparam logic SAVE    = 1'b0;
  localparam logic RESTORE = 1'b1;

endpackage

// File: rtl/salva_contexto_if.sv
// Control, register-file and memory signals of the context save/restore engine.
interface salva_contexto_if;
  logic        start;
  logic        modo;
  logic [31:0] baseAddr;
  logic        busy;
  logic        done;
  logic [4:0]  regAddr;
  logic [31:0] regDataIn;
  logic        regWrite;
  logic [31:0] regDataOut;
  logic [31:0] memAddr;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn;
  logic        memReady;

  // Engine side
  modport master (
    input  start, modo, baseAddr, regDataIn, memDataIn, memReady,
    output busy, done, regAddr, regWrite, regDataOut,
           memAddr, memWrite, memRead, memDataOut
  );

  // CPU / register file / memory side
  modport slave (
    output start, modo, baseAddr, regDataIn, memDataIn, memReady,
    input  busy, done, regAddr, regWrite, regDataOut,
           memAddr, memWrite, memRead, memDataOut
  );
endinterface

// File: rtl/salva_contexto.sv
// Context save/restore engine: moves registers FIRST_REG..LAST_REG to or from
// a word-addressed memory area starting at baseAddr, one word per handshake.
module salva_contexto
  import salva_contexto_pkg::*;
#(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input logic              clock,
  input logic              reset,
  salva_contexto_if.master bus
);

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  state_t      state, state_nx;
  logic [4:0]  idx;
  logic [31:0] base;
  logic [31:0] word;        // word captured from memory during restore
  logic [31:0] cur_addr;
  logic        last;

  // Values driven this cycle; the *_hold copies keep them stable when idle
  logic [4:0]  reg_addr,  reg_hold;
  logic [31:0] mem_addr,  addr_hold;
  logic [31:0] mem_wdata, wdata_hold;

  assign last     = (idx == LAST);
  // Offset adder wraps modulo 2^32
  assign cur_addr = base + {27'd0, idx - FIRST};

  assign bus.regAddr    = reg_addr;
  assign bus.memAddr    = mem_addr;
  assign bus.memDataOut = mem_wdata;
  assign bus.regDataOut = word;

  // State register; reset drops every strobe in the same cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and strobes; mode is latched implicitly by the branch taken from IDLE
  always_comb begin
    state_nx     = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.regWrite = 1'b0;
    bus.memWrite = 1'b0;
    bus.memRead  = 1'b0;
    reg_addr     = reg_hold;
    mem_addr     = addr_hold;
    mem_wdata    = wdata_hold;
    case (state)
      IDLE: begin
        if (bus.start) state_nx = (bus.modo == RESTORE) ? LOAD_REQ : SAVE_REQ;
      end
      SAVE_REQ: begin
        bus.busy     = 1'b1;
        bus.memWrite = 1'b1;
        mem_addr     = cur_addr;
        mem_wdata    = bus.regDataIn;
        reg_addr     = idx;
        if (bus.memReady) state_nx = last ? DONE : SAVE_REQ;
      end
      LOAD_REQ: begin
        bus.busy    = 1'b1;
        bus.memRead = 1'b1;
        mem_addr    = cur_addr;
        reg_addr    = idx;
        if (bus.memReady) state_nx = LOAD_WR;
      end
      LOAD_WR: begin
        bus.busy     = 1'b1;
        bus.regWrite = (idx != 5'd0);   // r0 is hard-wired, never written
        reg_addr     = idx;
        state_nx     = last ? DONE : LOAD_REQ;
      end
      DONE: begin
        bus.done = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Index, base latch and restore capture register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx  <= FIRST;
      base <= '0;
      word <= '0;
    end else begin
      case (state)
        IDLE:     if (bus.start) begin
                    idx  <= FIRST;
                    base <= bus.baseAddr;
                  end
        SAVE_REQ: if (bus.memReady && !last) idx <= idx + 5'd1;
        LOAD_REQ: if (bus.memReady) word <= bus.memDataIn;
        LOAD_WR:  if (!last) idx <= idx + 5'd1;
        default:  ;
      endcase
    end
  end

  // Remember the last driven address/data so outputs hold when idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg_hold   <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      reg_hold   <= reg_addr;
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_salva_contexto.sv
// Bench for salva_contexto: register file and memory models, a per-cycle
// transfer model, and directed save/restore/abort/wrap scenarios.
module tb_salva_contexto;
  localparam int FIRST = 1;
  localparam int LAST  = 31;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  salva_contexto_if bus();

  salva_contexto #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] rf [32];
  logic [31:0] mem [logic [31:0]];

  int checks = 0;
  int errors = 0;

  int mem_delay = 0;
  int wait_cnt  = 0;
  bit spurious  = 0;

  // transfer model
  bit          act = 0;
  bit          exp_mode = 0;
  logic [31:0] exp_base = 0;
  int          exp_k = FIRST;
  int          n_mem_wr = 0;
  int          n_reg_wr = 0;
  int          done_cyc = 0;
  logic [31:0] last_addr = 0;
  logic [31:0] last_wdata = 0;
  logic [4:0]  last_reg = 0;

  assign bus.regDataIn = rf[bus.regAddr];

  task automatic chk(string name, logic [31:0] act_v, logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endtask

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : (32'hDEAD0000 ^ a);
  endfunction

  // What the outputs must be this cycle, from the transfer rules
  task automatic check_cycle();
    logic [31:0] want_addr;
    want_addr = exp_base + 32'(exp_k - FIRST);
    chk("rd_wr_exclusive", {31'd0, bus.memRead & bus.memWrite}, 32'd0);
    chk("busy_vs_strobes", {31'd0, bus.busy},
        {31'd0, bus.memWrite | bus.memRead | bus.regWrite});
    if (!act)
      chk("idle_strobes", {28'd0, bus.memWrite, bus.memRead, bus.regWrite, bus.busy}, 32'd0);
    if (bus.memWrite) begin
      chk("save_mode", {31'd0, exp_mode}, 32'd0);
      chk("save_addr", bus.memAddr, want_addr);
      chk("save_data", bus.memDataOut, rf[exp_k[4:0]]);
      chk("save_reg",  {27'd0, bus.regAddr}, 32'(exp_k));
      last_addr  = bus.memAddr;
      last_wdata = bus.memDataOut;
      last_reg   = bus.regAddr;
      if (bus.memReady) begin
        mem[bus.memAddr] = bus.memDataOut;
        n_mem_wr++;
        exp_k++;
      end
    end
    if (bus.memRead) begin
      chk("load_mode", {31'd0, exp_mode}, 32'd1);
      chk("load_addr", bus.memAddr, want_addr);
      last_addr = bus.memAddr;
    end
    if (bus.regWrite) begin
      chk("restore_reg",  {27'd0, bus.regAddr}, 32'(exp_k));
      chk("restore_data", bus.regDataOut, mem_rd(want_addr));
      last_reg = bus.regAddr;
      rf[bus.regAddr] = bus.regDataOut;
      n_reg_wr++;
      exp_k++;
    end
    if (bus.done) begin
      chk("done_after_last", 32'(exp_k), 32'(LAST + 1));
      act = 0;
    end
    if (!bus.busy) begin
      chk("hold_mem_addr", bus.memAddr, last_addr);
      chk("hold_mem_data", bus.memDataOut, last_wdata);
      chk("hold_reg_addr", {27'd0, bus.regAddr}, {27'd0, last_reg});
    end
  endtask

  // Memory responder plus per-cycle compare, away from the active edge
  always @(negedge clock) begin
    if (!reset) begin
      bus.memReady = 1'b0;
      wait_cnt = 0;
    end else if (bus.memWrite || bus.memRead) begin
      if (wait_cnt >= mem_delay) begin
        bus.memReady = 1'b1;
        wait_cnt = 0;
      end else begin
        bus.memReady = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.memReady = spurious;
      wait_cnt = 0;
    end
    bus.memDataIn = mem_rd(bus.memAddr);
    #1;
    if (reset) check_cycle();
  end

  task automatic do_start(bit m, logic [31:0] b);
    @(negedge clock);
    bus.start = 1'b1; bus.modo = m; bus.baseAddr = b;
    @(posedge clock);
    act = 1; exp_mode = m; exp_base = b; exp_k = FIRST;
    n_mem_wr = 0; n_reg_wr = 0;
    #1;
    bus.start = 1'b0; bus.modo = ~m; bus.baseAddr = ~b;  // latched values must win
  endtask

  // Cycle 1 is the first cycle after the edge that accepted start
  task automatic wait_done(int budget);
    done_cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clock); #2;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
    end
    if (done_cyc < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.modo = 1'b0; bus.baseAddr = 32'h0;
    for (int k = 0; k < 32; k++) rf[k] = 32'(k * 3);

    // reset state
    #12;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_strobes", {29'd0, bus.regWrite, bus.memWrite, bus.memRead}, 32'd0);
    chk("rst_reg_addr", {27'd0, bus.regAddr}, 32'd0);
    chk("rst_mem_addr", bus.memAddr, 32'd0);
    chk("rst_mem_data", bus.memDataOut, 32'd0);
    chk("rst_reg_data", bus.regDataOut, 32'd0);
    @(negedge clock); reset = 1'b1;

    // no start after reset release, spurious memReady in IDLE
    spurious = 1;
    repeat (4) @(negedge clock);
    #2 chk("no_autostart", {31'd0, bus.busy}, 32'd0);
    spurious = 0;

    // save r1..r31 = 3*k to 0x100, ready every cycle, stray start mid-save
    mem_delay = 0;
    fork
      begin do_start(1'b0, 32'h100); wait_done(200); end
      begin
        repeat (12) @(negedge clock);
        bus.start = 1'b1; bus.modo = 1'b1; bus.baseAddr = 32'h999;
        @(negedge clock);
        bus.start = 1'b0;
      end
    join
    chk("save_done_cycle", 32'(done_cyc), 32'd32);
    chk("save_count", 32'(n_mem_wr), 32'd31);
    chk("save_mem_100", mem_rd(32'h100), 32'd3);
    chk("save_mem_11E", mem_rd(32'h11E), 32'd93);
    chk("stray_base_unused", {31'd0, mem.exists(32'h999) ? 1'b1 : 1'b0}, 32'd0);
    for (int k = 1; k <= 31; k++)
      chk("save_mem_k", mem_rd(32'h100 + 32'(k - 1)), 32'(3 * k));

    // restore from 0x200, two wait cycles per word, spurious ready in LOAD_WR
    for (int k = 0; k < 31; k++) mem[32'h200 + 32'(k)] = 32'hA000 + 32'(k);
    rf[0] = 32'h5A5A;
    mem_delay = 2; spurious = 1;
    do_start(1'b1, 32'h200);
    wait_done(400);
    spurious = 0;
    chk("restore_done_cycle", 32'(done_cyc), 32'd125);
    chk("restore_count", 32'(n_reg_wr), 32'd31);
    chk("restore_r0", rf[0], 32'h5A5A);
    chk("restore_r1", rf[1], 32'hA000);
    chk("restore_r31", rf[31], 32'hA01E);
    for (int k = 1; k <= 31; k++)
      chk("restore_rk", rf[k], 32'hA000 + 32'(k - 1));

    // reset during restore while fetching r10
    for (int k = 0; k < 31; k++) mem[32'h300 + 32'(k)] = 32'hB000 + 32'(k);
    for (int k = 1; k < 32; k++) rf[k] = 32'h1111_0000 + 32'(k);
    mem_delay = 2;
    do_start(1'b1, 32'h300);
    for (int c = 0; c < 200 && n_reg_wr < 9; c++) begin
      @(negedge clock); #2;
    end
    chk("abort_reached_r9", 32'(n_reg_wr), 32'd9);
    @(posedge clock); #2;
    chk("abort_pre_read", {31'd0, bus.memRead}, 32'd1);
    chk("abort_pre_addr", bus.memAddr, 32'h309);
    reset = 1'b0;
    act = 0; exp_k = FIRST;
    last_addr = 0; last_wdata = 0; last_reg = 0;
    #1;
    chk("abort_strobes", {29'd0, bus.regWrite, bus.memWrite, bus.memRead}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_mem_addr", bus.memAddr, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    #2 chk("abort_idle_after", {31'd0, bus.busy}, 32'd0);
    chk("abort_count", 32'(n_reg_wr), 32'd9);
    for (int k = 1; k <= 9; k++)
      chk("abort_restored", rf[k], 32'hB000 + 32'(k - 1));
    for (int k = 10; k <= 31; k++)
      chk("abort_untouched", rf[k], 32'h1111_0000 + 32'(k));

    // save with base near the top of memory: address wraps at r17
    for (int k = 1; k < 32; k++) rf[k] = 32'hC000_0000 + 32'(k);
    mem_delay = 1;
    do_start(1'b0, 32'hFFFF_FFF0);
    wait_done(200);
    chk("wrap_done_cycle", 32'(done_cyc), 32'd63);
    chk("wrap_mem_FFFFFFFF", mem_rd(32'hFFFF_FFFF), 32'hC000_0010);
    chk("wrap_mem_0", mem_rd(32'h0), 32'hC000_0011);
    chk("wrap_mem_E", mem_rd(32'hE), 32'hC000_001F);
    chk("wrap_hold_addr", bus.memAddr, 32'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
